// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver for a 4-bit counter value.
// Digits 1:0 show decimal with leading-zero suppression, digit 3 shows hex, digit 2 is dark.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       load,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [6:0]       SEG_OFF   = 7'b1111111;

  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_e;

  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  slot_e            slot;
  logic             tens;
  logic [3:0]       units;
  logic             dark;

  // Cathode patterns, gfedcba, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 4'd0;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  always_comb begin
    hold_d = load ? value : hold_q;
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Each slot opens with a blanking window so the previous digit's pattern never ghosts.
  always_comb begin
    slot = (cnt_q < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
  end

  always_comb begin
    tens  = (hold_q >= 4'd10);
    units = tens ? (hold_q - 4'd10) : hold_q;
    dark  = (slot == SLOT_BLANK) || blank || (idx_q == 2'd2) ||
            ((idx_q == 2'd1) && !tens);
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!dark) begin
      an_d = ~(4'b0001 << idx_q);
      case (idx_q)
        2'd0:    seg_d = glyph(units);
        2'd1:    seg_d = glyph(4'd1);
        2'd3: begin
          seg_d = glyph(hold_q);
          dp_d  = 1'b0;
        end
        default: seg_d = SEG_OFF;
      endcase
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=8, BLANK_CYC=2.
module tb_seven_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value = 4'd0;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seven_seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank(blank),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] OFF = 12'hFFF;

  int n_cmp = 0;
  int n_bad = 0;
  int rc = 0;
  int ri = 0;
  logic [3:0][11:0] tab0, tab7, tab13, tab5, tab9;

  function automatic logic [11:0] mk(input logic [3:0] a, input logic [6:0] s, input logic d);
    return {a, s, d};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got an/seg/dp=%b/%b/%b want %b/%b/%b", tag,
               got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // One clock per iteration; rc/ri track where the scan should be before each edge.
  task automatic run(input string tag, input int n, input logic [3:0][11:0] tab);
    for (int k = 0; k < n; k++) begin
      logic prst, pb;
      int pc, pi;
      logic [11:0] exp;
      @(posedge clk);
      prst = rst;
      pb   = blank;
      pc   = rc;
      pi   = ri;
      if (rst) begin
        rc = 0;
        ri = 0;
      end else if (rc == 7) begin
        rc = 0;
        ri = (ri + 1) % 4;
      end else begin
        rc++;
      end
      #1;
      exp = (prst || pb || pc < 2) ? OFF : tab[pi];
      chk($sformatf("%s[%0d] idx%0d cnt%0d", tag, k, pi, pc), {an, seg, dp}, exp);
    end
  endtask

  task automatic seek(input string tag, input int c, input int i, input logic [3:0][11:0] tab);
    for (int k = 0; k < 64; k++) begin
      if (rc == c && ri == i) break;
      run(tag, 1, tab);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    tab0  = {mk(4'b0111, 7'b1000000, 1'b0), OFF, OFF, mk(4'b1110, 7'b1000000, 1'b1)};
    tab7  = {mk(4'b0111, 7'b1111000, 1'b0), OFF, OFF, mk(4'b1110, 7'b1111000, 1'b1)};
    tab13 = {mk(4'b0111, 7'b0100001, 1'b0), OFF, mk(4'b1101, 7'b1111001, 1'b1),
             mk(4'b1110, 7'b0110000, 1'b1)};
    tab5  = {mk(4'b0111, 7'b0010010, 1'b0), OFF, OFF, mk(4'b1110, 7'b0010010, 1'b1)};
    tab9  = {mk(4'b0111, 7'b0010000, 1'b0), OFF, OFF, mk(4'b1110, 7'b0010000, 1'b1)};

    run("reset", 2, tab0);
    rst = 1'b0;
    run("post_reset", 16, tab0);

    value = 4'd7;
    load  = 1'b1;
    run("load7", 1, tab0);
    load = 1'b0;
    run("val7", 32, tab7);

    seek("seek_wrap", 7, ri, tab7);
    value = 4'd13;
    load  = 1'b1;
    run("load13_wrap", 1, tab7);
    load = 1'b0;
    run("val13", 32, tab13);

    value = 4'd5;
    load  = 1'b1;
    run("load5", 1, tab13);
    load  = 1'b0;
    value = 4'd9;
    run("no_load", 32, tab5);

    seek("seek_idx0", 3, 0, tab5);
    load = 1'b1;
    run("lat_load_edge", 1, tab5);
    load = 1'b0;
    run("lat_next", 1, tab9);
    run("after9", 8, tab9);

    blank = 1'b1;
    run("blank", 20, tab9);
    blank = 1'b0;
    run("unblank", 32, tab9);

    seek("seek_idx3", 5, 3, tab9);
    rst   = 1'b1;
    value = 4'd13;
    load  = 1'b1;
    run("rst_mid", 1, tab9);
    rst  = 1'b0;
    load = 1'b0;
    run("restart", 32, tab0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
